// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   - uart_state_e : bit-level FSM state encoding (IDLE, START, DATA, STOP)
//   - OVERSAMPLE   : oversample ticks per bit period
//   - MID_SAMPLE   : tick count at the middle of the start bit
//   - LAST_SAMPLE  : tick count one full bit period after the previous sample
//   - uart_div()   : clock divider for the oversample tick, never below 1
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam logic [3:0]  MID_SAMPLE  = 4'd7;
  localparam logic [3:0]  LAST_SAMPLE = 4'd15;

  // Integer-truncated divider; a zero result (very fast line) is clamped to 1
  // so the tick still fires every clock.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned div;
    div = clk_hz / (baud * oversample);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-clock oversample tick every DIV cycles.
// Shared between the receiver and the transmitter.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   tick_o  out  registered one-cycle tick pulse
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Divider counter and registered tick; with DIV=1 the tick stays high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_word_rx_core.sv
// -----------------------------------------------------------------------------
// uart_word_rx_core
// 8N1 UART receiver assembling little-endian 32-bit words (or single bytes on
// request) with glitch rejection, framing-error detection and an inter-byte
// timeout that discards stale partial words.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   rx        in   asynchronous UART line, idle high
//   one_byte  in   1 = next completed word is a single byte
//   data_out  out  last completed word/byte (byte zero-extended)
//   data_end  out  one-cycle pulse: data_out just updated
//   rx_error  out  one-cycle pulse: framing error or timeout discarded data
//   busy      out  frame or partial word in progress
// -----------------------------------------------------------------------------
module uart_word_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        one_byte,
  output logic [31:0] data_out,
  output logic        data_end,
  output logic        rx_error,
  output logic        busy
);

  localparam int unsigned     DIV      = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned     TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int unsigned     TO_W     = $clog2(TO_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_TICKS - 1);

  logic              sync1_q;
  logic              sync2_q;
  logic              rx_s;
  logic              tick_s;

  uart_state_e       state_q;
  logic [3:0]        os_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       word_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              armed_q;
  logic [31:0]       data_out_q;
  logic              data_end_q;
  logic              rx_error_q;
  logic              busy_q;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick_s)
  );

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Bit FSM, word assembly, timeout and registered outputs.
  // busy is updated on every transition that changes the FSM state or the
  // byte count so it always equals (state != IDLE) || (byte_cnt != 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      os_cnt_q   <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 24'd0;
      to_cnt_q   <= '0;
      armed_q    <= 1'b1;
      data_out_q <= 32'd0;
      data_end_q <= 1'b0;
      rx_error_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      data_end_q <= 1'b0;
      rx_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!armed_q) begin
            // After a framing error the line must return high before a new
            // falling edge is trusted as a start bit.
            if (rx_s) begin
              armed_q <= 1'b1;
            end
          end else if (!rx_s) begin
            // Start detection has priority over a simultaneous timeout.
            state_q  <= ST_START;
            os_cnt_q <= 4'd0;
            to_cnt_q <= '0;
            busy_q   <= 1'b1;
          end else if ((byte_cnt_q != 2'd0) && tick_s) begin
            if (to_cnt_q == TO_LAST) begin
              byte_cnt_q <= 2'd0;
              to_cnt_q   <= '0;
              rx_error_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
        end

        ST_START: begin
          if (tick_s) begin
            if (os_cnt_q == MID_SAMPLE) begin
              os_cnt_q <= 4'd0;
              if (!rx_s) begin
                state_q   <= ST_DATA;
                bit_idx_q <= 3'd0;
              end else begin
                // Line came back high before mid-bit: a glitch, not a frame.
                state_q <= ST_IDLE;
                busy_q  <= (byte_cnt_q != 2'd0);
              end
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end
        end

        ST_DATA: begin
          if (tick_s) begin
            if (os_cnt_q == LAST_SAMPLE) begin
              os_cnt_q  <= 4'd0;
              shift_q   <= {rx_s, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                state_q <= ST_STOP;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end
        end

        ST_STOP: begin
          if (tick_s) begin
            if (os_cnt_q == LAST_SAMPLE) begin
              os_cnt_q <= 4'd0;
              state_q  <= ST_IDLE;
              if (!rx_s) begin
                // Framing error: drop this byte and any partial word.
                byte_cnt_q <= 2'd0;
                rx_error_q <= 1'b1;
                armed_q    <= 1'b0;
                busy_q     <= 1'b0;
              end else if ((byte_cnt_q == 2'd0) && one_byte) begin
                data_out_q <= {24'd0, shift_q};
                data_end_q <= 1'b1;
                busy_q     <= 1'b0;
              end else begin
                case (byte_cnt_q)
                  2'd0: begin
                    word_q[7:0] <= shift_q;
                    byte_cnt_q  <= 2'd1;
                    busy_q      <= 1'b1;
                  end
                  2'd1: begin
                    word_q[15:8] <= shift_q;
                    byte_cnt_q   <= 2'd2;
                    busy_q       <= 1'b1;
                  end
                  2'd2: begin
                    word_q[23:16] <= shift_q;
                    byte_cnt_q    <= 2'd3;
                    busy_q        <= 1'b1;
                  end
                  2'd3: begin
                    data_out_q <= {shift_q, word_q};
                    data_end_q <= 1'b1;
                    byte_cnt_q <= 2'd0;
                    busy_q     <= 1'b0;
                  end
                  default: begin
                    byte_cnt_q <= 2'd0;
                    busy_q     <= 1'b0;
                  end
                endcase
              end
            end else begin
              os_cnt_q <= os_cnt_q + 4'd1;
            end
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          os_cnt_q <= 4'd0;
          busy_q   <= (byte_cnt_q != 2'd0);
        end
      endcase
    end
  end

  assign data_out = data_out_q;
  assign data_end = data_end_q;
  assign rx_error = rx_error_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_word_rx_core.sv
module tb_uart_word_rx_core;

  localparam int unsigned CLK_HZ       = 16_000_000;
  localparam int unsigned BAUD         = 1_000_000;
  localparam int unsigned TIMEOUT_BITS = 40;
  localparam int          BIT_CLKS     = 16;
  // Line start edge -> data_end sampled: 9.5 bit periods to stop mid-bit,
  // plus 2 synchronizer cycles, plus 1 registered-output cycle.
  localparam int          END_LATENCY  = 155;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        one_byte;
  logic [31:0] data_out;
  logic        data_end;
  logic        rx_error;
  logic        busy;

  always #5 clk = ~clk;

  uart_word_rx_core #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .OVERSAMPLE   (16),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .one_byte (one_byte),
    .data_out (data_out),
    .data_end (data_end),
    .rx_error (rx_error),
    .busy     (busy)
  );

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] part_q[$];

  int n_pass          = 0;
  int n_total         = 0;
  int cyc             = 0;
  int last_end_cyc    = 0;
  int frame_start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  // ---------------- reference model ----------------
  task automatic model_byte(input logic [7:0] b, input logic ob);
    logic [31:0] w;
    if (part_q.size() == 0 && ob) begin
      exp_q.push_back({1'b0, 24'd0, b});
    end else begin
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        w = 32'd0;
        for (int k = 0; k < 4; k++) w = w + (32'(part_q[k]) << (8 * k));
        exp_q.push_back({1'b0, w});
        part_q.delete();
      end
    end
  endtask

  task automatic model_error();
    exp_q.push_back({1'b1, 32'd0});
    part_q.delete();
  endtask

  // ---------------- line driver (entered at posedge+1) ----------------
  task automatic line_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    frame_start_cyc = cyc;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(stop);
    rx = 1'b1;
  endtask

  task automatic good(input logic [7:0] b);
    model_byte(b, one_byte);
    send_frame(b, 1'b1);
  endtask

  task automatic bad(input logic [7:0] b);
    model_error();
    send_frame(b, 1'b0);
    line_bit(1'b1);
  endtask

  task automatic gap(input int n);
    if (n > TIMEOUT_BITS && part_q.size() != 0) model_error();
    repeat (n) line_bit(1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, data_out, 32'd0);
    check({tag, "_data_end"}, {31'd0, data_end}, 32'd0);
    check({tag, "_rx_error"}, {31'd0, rx_error}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t        e;
    logic        prev_end;
    logic [31:0] prev_dout;
    logic        dout_changed;
    prev_end     = 1'b0;
    prev_dout    = 32'd0;
    dout_changed = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_end     = 1'b0;
        prev_dout    = data_out;
        dout_changed = 1'b0;
      end else begin
        if (data_end) begin
          last_end_cyc = cyc;
          check("data_end_width", {31'd0, prev_end}, 32'd0);
          check("data_out_held", {31'd0, dout_changed}, 32'd0);
          dout_changed = 1'b0;
          check("pending_for_data_end", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event_is_data", {31'd0, e.is_err}, 32'd0);
            check("data_out", data_out, e.data);
          end
        end else if (data_out !== prev_dout) begin
          dout_changed = 1'b1;
        end
        if (rx_error) begin
          check("pending_for_rx_error", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event_is_error", {31'd0, e.is_err}, 32'd1);
          end
        end
        prev_end  = data_end;
        prev_dout = data_out;
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [7:0] rb;
    reset    = 1'b1;
    rx       = 1'b1;
    one_byte = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Single byte with latency check
    one_byte = 1'b1;
    good(8'h02);
    check("single_byte_latency", 32'(last_end_cyc - frame_start_cyc), 32'(END_LATENCY));
    gap(2);

    // Back-to-back word
    one_byte = 1'b0;
    good(8'h13); good(8'h05); good(8'h00); good(8'h00);
    gap(2);

    // Glitch rejection
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_busy", {31'd0, busy}, 32'd0);
    one_byte = 1'b1;
    good(8'hA5);
    gap(2);

    // Framing error mid-word, then a full word
    one_byte = 1'b0;
    good(8'h31); good(8'h32);
    check("midword_busy", {31'd0, busy}, 32'd1);
    bad(8'h11);
    check("after_ferr_busy", {31'd0, busy}, 32'd0);
    good(8'hEF); good(8'hBE); good(8'hAD); good(8'hDE);
    gap(2);

    // Inter-byte timeout
    good(8'h55); good(8'h66);
    model_error();
    repeat (10) line_bit(1'b1);
    check("before_timeout_busy", {31'd0, busy}, 32'd1);
    repeat (31) line_bit(1'b1);
    check("after_timeout_busy", {31'd0, busy}, 32'd0);
    good(8'h01); good(8'h02); good(8'h03); good(8'h04);
    gap(2);

    // Reset during bit 5 of byte 2
    good(8'h77);
    rb = 8'h88;
    line_bit(1'b0);
    for (int i = 0; i < 5; i++) line_bit(rb[i]);
    rx = rb[5];
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    rx    = 1'b1;
    part_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) line_bit(1'b1);
    good(8'h0A); good(8'h0B); good(8'h0C); good(8'h0D);
    gap(2);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      one_byte = 1'($urandom_range(0, 1));
      rb = 8'($urandom);
      if ($urandom_range(0, 11) == 0) bad(rb);
      else good(rb);
      if ($urandom_range(0, 7) == 0) gap(45);
      else gap(int'($urandom_range(0, 3)));
    end
    gap(2);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
